// File: rtl/half_pkg.sv
// Shared binary16 definitions for the half-precision datapath blocks.
// Contents: field widths and bias, half_t operand layout, operand classes,
// and the half_to_int converter state encoding.
package half_pkg;

  localparam int unsigned HALF_W   = 16;
  localparam int unsigned EXP_W    = 5;
  localparam int unsigned MAN_W    = 10;
  localparam int unsigned EXP_BIAS = 15;
  localparam int unsigned EXP_MAX  = 31;

  // Significand with hidden bit, and an accumulator wide enough for the
  // largest finite left shift (exp 30 -> 15 positions).
  localparam int unsigned SIG_W = MAN_W + 1;
  localparam int unsigned ACC_W = SIG_W + EXP_MAX - 1 - EXP_BIAS;
  localparam int unsigned CNT_W = 4;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W-1:0] man;
  } half_t;

  typedef enum logic [2:0] {HC_ZERO, HC_SUB, HC_NORM, HC_INF, HC_NAN} half_class_t;

  typedef enum logic [1:0] {IDLE, ALIGN, PACK, DONE} h2i_state_t;

endpackage

// File: rtl/half_unpack.sv
// Combinational binary16 field decoder, shared by half-precision blocks.
// Ports:
//   op    in   half_t        operand
//   cls   out  half_class_t  zero / subnormal / normal / inf / NaN
//   sign  out  1             sign bit
//   sig   out  SIG_W         significand, hidden bit included for normals
//   uexp  out  EXP_W+1 s     unbiased exponent (subnormals use 1-bias)
module half_unpack
  import half_pkg::*;
(
  input  half_t                   op,
  output half_class_t             cls,
  output logic                    sign,
  output logic [SIG_W-1:0]        sig,
  output logic signed [EXP_W:0]   uexp
);

  always_comb begin
    sign = op.sign;
    cls  = HC_NORM;
    sig  = {1'b1, op.man};
    uexp = $signed((EXP_W+1)'(op.exp)) - $signed((EXP_W+1)'(EXP_BIAS));
    if (op.exp == '0) begin
      sig  = {1'b0, op.man};
      uexp = $signed((EXP_W+1)'(1)) - $signed((EXP_W+1)'(EXP_BIAS));
      cls  = (op.man == '0) ? HC_ZERO : HC_SUB;
    end else if (op.exp == EXP_W'(EXP_MAX)) begin
      cls = (op.man == '0) ? HC_INF : HC_NAN;
    end
  end

endmodule

// File: rtl/half_to_int.sv
// Multi-cycle binary16 -> signed INT_W converter; truncates toward zero,
// saturates out-of-range and infinite operands, flags NaN and inexact.
// Ports:
//   clk, nrst             clock; asynchronous active-high reset
//   in_valid/in_ready     operand handshake (ready only when idle)
//   in_half               binary16 operand
//   out_valid/out_ready   result handshake
//   out_int               signed result
//   out_ovf/inv/inx       saturated / NaN operand / fraction discarded
module half_to_int
  import half_pkg::*;
#(
  parameter int unsigned INT_W = 16
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [HALF_W-1:0] in_half,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [INT_W-1:0]  out_int,
  output logic              out_ovf,
  output logic              out_inv,
  output logic              out_inx
);

  // Magnitude compares are done in a width that holds both the 16-bit
  // integer part and 2^(INT_W-1) for INT_W up to 32.
  localparam int unsigned      CMP_W   = 34;
  localparam logic [CMP_W-1:0] MAX_MAG = CMP_W'((64'd1 << (INT_W - 1)) - 64'd1);
  localparam logic [CMP_W-1:0] MIN_MAG = CMP_W'(64'd1 << (INT_W - 1));
  localparam logic [INT_W-1:0] MAX_INT = {1'b0, {(INT_W-1){1'b1}}};
  localparam logic [INT_W-1:0] MIN_INT = {1'b1, {(INT_W-1){1'b0}}};

  h2i_state_t         state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  half_class_t        cls_q, cls_d;
  logic               sign_q, sign_d;
  logic               lt_one_q, lt_one_d;
  logic [INT_W-1:0]   out_int_d;
  logic               out_valid_d, out_ovf_d, out_inv_d, out_inx_d;

  half_class_t          u_cls;
  logic                 u_sign;
  logic [SIG_W-1:0]     u_sig;
  logic signed [EXP_W:0] u_uexp;

  logic [CMP_W-1:0]     mag_w;
  logic                 frac_nz;

  half_unpack u_unpack (
    .op   (half_t'(in_half)),
    .cls  (u_cls),
    .sign (u_sign),
    .sig  (u_sig),
    .uexp (u_uexp)
  );

  assign in_ready = (state_q == IDLE);
  assign mag_w    = CMP_W'(acc_q[ACC_W-1:MAN_W]);
  assign frac_nz  = |acc_q[MAN_W-1:0];

  // Next-state, datapath and output-register next values
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    cls_d       = cls_q;
    sign_d      = sign_q;
    lt_one_d    = lt_one_q;
    out_valid_d = out_valid;
    out_int_d   = out_int;
    out_ovf_d   = out_ovf;
    out_inv_d   = out_inv;
    out_inx_d   = out_inx;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          acc_d    = ACC_W'(u_sig);
          cls_d    = u_cls;
          sign_d   = u_sign;
          // |x| < 1 includes normals with a negative unbiased exponent
          lt_one_d = (u_cls == HC_ZERO) || (u_cls == HC_SUB) ||
                     ((u_cls == HC_NORM) && u_uexp[EXP_W]);
          cnt_d    = ((u_cls == HC_NORM) && !u_uexp[EXP_W]) ? CNT_W'(u_uexp) : '0;
          state_d  = ALIGN;
        end
      end

      ALIGN: begin
        if (cnt_q != '0) begin
          acc_d = acc_q << 1;
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          state_d = PACK;
        end
      end

      PACK: begin
        out_int_d   = '0;
        out_ovf_d   = 1'b0;
        out_inv_d   = 1'b0;
        out_inx_d   = 1'b0;
        out_valid_d = 1'b1;
        state_d     = DONE;
        if (cls_q == HC_NAN) begin
          out_inv_d = 1'b1;
        end else if (cls_q == HC_INF) begin
          out_ovf_d = 1'b1;
          out_int_d = sign_q ? MIN_INT : MAX_INT;
        end else if (lt_one_q) begin
          out_inx_d = (cls_q != HC_ZERO);
        end else if (!sign_q) begin
          if (mag_w > MAX_MAG) begin
            out_ovf_d = 1'b1;
            out_int_d = MAX_INT;
          end else begin
            out_int_d = INT_W'(mag_w);
            out_inx_d = frac_nz;
          end
        end else begin
          // Exactly 2^(INT_W-1) negates to MIN without saturating
          if (mag_w > MIN_MAG) begin
            out_ovf_d = 1'b1;
            out_int_d = MIN_INT;
          end else begin
            out_int_d = INT_W'(CMP_W'(0) - mag_w);
            out_inx_d = frac_nz;
          end
        end
      end

      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State, datapath and output registers
  always_ff @(posedge clk or posedge nrst) begin
    if (nrst) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      cnt_q     <= '0;
      cls_q     <= HC_ZERO;
      sign_q    <= 1'b0;
      lt_one_q  <= 1'b0;
      out_valid <= 1'b0;
      out_int   <= '0;
      out_ovf   <= 1'b0;
      out_inv   <= 1'b0;
      out_inx   <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      cls_q     <= cls_d;
      sign_q    <= sign_d;
      lt_one_q  <= lt_one_d;
      out_valid <= out_valid_d;
      out_int   <= out_int_d;
      out_ovf   <= out_ovf_d;
      out_inv   <= out_inv_d;
      out_inx   <= out_inx_d;
    end
  end

endmodule

// File: tb/tb_half_to_int.sv
// Self-checking bench for half_to_int: INT_W=16 and INT_W=32 instances
// share stimulus; results compared with an arithmetic reference model.
module tb_half_to_int;

  logic        clk = 1'b0;
  logic        nrst;
  logic        in_valid;
  logic        out_ready;
  logic [15:0] in_half;

  logic        in_ready, out_valid, out_ovf, out_inv, out_inx;
  logic [15:0] out_int;
  logic        in_ready32, out_valid32, ovf32, inv32, inx32;
  logic [31:0] out_int32;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  half_to_int #(.INT_W(16)) dut (
    .clk(clk), .nrst(nrst), .in_valid(in_valid), .in_ready(in_ready),
    .in_half(in_half), .out_valid(out_valid), .out_ready(out_ready),
    .out_int(out_int), .out_ovf(out_ovf), .out_inv(out_inv), .out_inx(out_inx)
  );

  half_to_int #(.INT_W(32)) dut32 (
    .clk(clk), .nrst(nrst), .in_valid(in_valid), .in_ready(in_ready32),
    .in_half(in_half), .out_valid(out_valid32), .out_ready(out_ready),
    .out_int(out_int32), .out_ovf(ovf32), .out_inv(inv32), .out_inx(inx32)
  );

  // Reference: value = (1024+man) * 2^(exp-25); truncate, then clamp.
  // Flags returned as {ovf, inv, inx}.
  function automatic void model(input logic [15:0] h, input int w,
                                output longint v, output logic [2:0] f,
                                output int lat);
    int     e, m;
    logic   s;
    longint maxv, minv, scaled, mag, val;
    s    = h[15];
    e    = int'(h[14:10]);
    m    = int'(h[9:0]);
    maxv = (longint'(1) << (w - 1)) - 1;
    minv = -(longint'(1) << (w - 1));
    v    = 0;
    f    = 3'b000;
    lat  = 2;
    if (e == 31) begin
      if (m != 0) f = 3'b010;
      else begin
        f = 3'b100;
        v = s ? minv : maxv;
      end
    end else if (e < 15) begin
      f = (e == 0 && m == 0) ? 3'b000 : 3'b001;
    end else begin
      lat    = e - 15 + 2;
      scaled = longint'(1024 + m) * (longint'(1) << (e - 15));
      mag    = scaled / 1024;
      val    = s ? -mag : mag;
      if (val > maxv) begin
        v = maxv; f = 3'b100;
      end else if (val < minv) begin
        v = minv; f = 3'b100;
      end else begin
        v = val;
        f = {2'b00, (scaled % 1024) != 0};
      end
    end
  endfunction

  // One full conversion on both instances with result and latency checks
  task automatic run_conv(input logic [15:0] h, input string name);
    longint ev16, ev32;
    logic [2:0] ef16, ef32;
    int elat, lat;
    model(h, 16, ev16, ef16, elat);
    model(h, 32, ev32, ef32, elat);
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || in_ready32 !== 1'b1) begin
      failures++;
      $display("FAIL %s in_ready_before_accept got=%b/%b want=1", name, in_ready, in_ready32);
    end
    in_half  = h;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_half  = 16'($urandom);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (lat !== elat) begin
      failures++;
      $display("FAIL %s latency h=%h got=%0d want=%0d", name, h, lat, elat);
    end
    checks++;
    if (longint'($signed(out_int)) !== ev16) begin
      failures++;
      $display("FAIL %s int16 h=%h got=%0d want=%0d", name, h, $signed(out_int), ev16);
    end
    checks++;
    if ({out_ovf, out_inv, out_inx} !== ef16) begin
      failures++;
      $display("FAIL %s flags16 h=%h got=%b want=%b", name, h, {out_ovf, out_inv, out_inx}, ef16);
    end
    checks++;
    if (out_valid32 !== 1'b1 || longint'($signed(out_int32)) !== ev32 ||
        {ovf32, inv32, inx32} !== ef32) begin
      failures++;
      $display("FAIL %s int32 h=%h got=%0d/%b/v%b want=%0d/%b", name, h,
               $signed(out_int32), {ovf32, inv32, inx32}, out_valid32, ev32, ef32);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || longint'($signed(out_int)) !== ev16 ||
        {out_ovf, out_inv, out_inx} !== ef16) begin
      failures++;
      $display("FAIL %s after_handshake valid=%b int=%0d flags=%b want valid=0 int=%0d flags=%b",
               name, out_valid, $signed(out_int), {out_ovf, out_inv, out_inx}, ev16, ef16);
    end
  endtask

  task automatic test_reset();
    nrst      = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_half   = 16'h0000;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_int !== 16'd0 ||
        {out_ovf, out_inv, out_inx} !== 3'b000 || out_valid32 !== 1'b0 ||
        in_ready32 !== 1'b1 || out_int32 !== 32'd0) begin
      failures++;
      $display("FAIL reset_state valid=%b ready=%b int=%h flags=%b int32=%h want 0/1/0/000/0",
               out_valid, in_ready, out_int, {out_ovf, out_inv, out_inx}, out_int32);
    end
    @(negedge clk);
    nrst = 1'b0;
  endtask

  task automatic test_directed();
    logic [15:0] vec [16] = '{16'h4200, 16'h3C00, 16'hC648, 16'h3800, 16'h8000,
                              16'h0001, 16'h7BFF, 16'hF800, 16'h7C00, 16'hFC00,
                              16'h7E00, 16'h0000, 16'hFBFF, 16'h7800, 16'h77FF,
                              16'h3BFF};
    for (int i = 0; i < 16; i++) run_conv(vec[i], "directed");
  endtask

  task automatic test_random();
    for (int i = 0; i < 150; i++) run_conv(16'($urandom_range(0, 65535)), "random");
  endtask

  // Stall the result while a new operand waits; it must enter only after release
  task automatic test_back_to_back();
    int lat;
    @(negedge clk);
    in_half  = 16'h4200;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_half = 16'h4500;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (lat !== 3) begin
      failures++;
      $display("FAIL stall_first_latency got=%0d want=3", lat);
    end
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_int !== 16'd3 ||
          {out_ovf, out_inv, out_inx} !== 3'b000) begin
        failures++;
        $display("FAIL stall_hold cycle=%0d valid=%b ready=%b int=%0d flags=%b want 1/0/3/000",
                 c, out_valid, in_ready, $signed(out_int), {out_ovf, out_inv, out_inx});
      end
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL stall_release valid=%b ready=%b want 0/1", out_valid, in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL stall_second_accept ready=%b want=0", in_ready);
    end
    lat = 0;
    while (out_valid !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (lat !== 4 || out_int !== 16'd5 || {out_ovf, out_inv, out_inx} !== 3'b000) begin
      failures++;
      $display("FAIL stall_second_result lat=%0d int=%0d flags=%b want 4/5/000",
               lat, $signed(out_int), {out_ovf, out_inv, out_inx});
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  // Reset while shifting a long-latency operand must drop it
  task automatic test_reset_midflight();
    bit seen;
    @(negedge clk);
    in_half  = 16'h7BFF;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    nrst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_int !== 16'd0 ||
        {out_ovf, out_inv, out_inx} !== 3'b000 || out_int32 !== 32'd0) begin
      failures++;
      $display("FAIL midflight_reset valid=%b ready=%b int=%h flags=%b int32=%h want 0/1/0/000/0",
               out_valid, in_ready, out_int, {out_ovf, out_inv, out_inx}, out_int32);
    end
    @(negedge clk);
    nrst = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      failures++;
      $display("FAIL midflight_dropped out_valid rose=%b want=0", seen);
    end
    run_conv(16'h4500, "post_reset");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_midflight();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
